// File: rtl/lc3_mem_arbiter_if.sv
// Bundle between the LC-3 memory arbiter, its two requesters (CPU, DMA/IO) and the memory port.
// The arbiter connects through the slave modport; the requesters and memory model use master.
interface lc3_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rdy;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_rdy;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          owner;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_rdy,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_rdy,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_rdy,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_rdy,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Single-port LC-3 memory arbiter: fixed CPU priority with a DMA anti-starvation override,
// fixed wait-state access sequencing and a one-cycle ready pulse to the winning requester.
module lc3_mem_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic                clk,
    input  logic                rst,
    lc3_mem_arbiter_if.slave    io_bus
);

    localparam int WW = $clog2(WAIT_CYCLES + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [WW-1:0] WC_LAST    = WW'(WAIT_CYCLES - 1);
    localparam logic [WW-1:0] WC_ONE     = WW'(1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [WW-1:0] r_wait_cnt, w_wait_nxt;
    logic [SW-1:0] r_starve_cnt, w_starve_nxt;
    logic          r_we_intent, w_we_intent_nxt;
    logic          r_owner, w_owner_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic          r_mem_en, w_mem_en_nxt;
    logic          r_mem_we, w_mem_we_nxt;
    logic          r_cpu_rdy, w_cpu_rdy_nxt;
    logic          r_dma_rdy, w_dma_rdy_nxt;
    logic [DW-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
    logic [DW-1:0] r_dma_rdata, w_dma_rdata_nxt;
    logic          w_grant_dma;
    logic          w_sel_we;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, grant decision and next values of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait_cnt;
        w_starve_nxt    = r_starve_cnt;
        w_we_intent_nxt = r_we_intent;
        w_owner_nxt     = r_owner;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_cpu_rdy_nxt   = 1'b0;
        w_dma_rdy_nxt   = 1'b0;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_dma_rdata_nxt = r_dma_rdata;
        // DMA wins when alone, or when the CPU has been favoured STARVE_MAX times in a row
        w_grant_dma     = io_bus.dma_req && (!io_bus.cpu_req || (r_starve_cnt == STARVE_LIM));
        w_sel_we        = w_grant_dma ? io_bus.dma_we : io_bus.cpu_we;

        case (r_state)
            ST_IDLE: begin
                if (io_bus.cpu_req || io_bus.dma_req) begin
                    w_state_nxt     = ST_ACCESS;
                    w_wait_nxt      = {WW{1'b0}};
                    w_owner_nxt     = w_grant_dma;
                    w_we_intent_nxt = w_sel_we;
                    w_mem_addr_nxt  = w_grant_dma ? io_bus.dma_addr  : io_bus.cpu_addr;
                    w_mem_wdata_nxt = w_grant_dma ? io_bus.dma_wdata : io_bus.cpu_wdata;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = w_sel_we && (WC_LAST == {WW{1'b0}});
                    if (w_grant_dma) begin
                        w_starve_nxt = {SW{1'b0}};
                    end else if (io_bus.dma_req && (r_starve_cnt != STARVE_LIM)) begin
                        w_starve_nxt = r_starve_cnt + STARVE_ONE;
                    end else begin
                        w_starve_nxt = r_starve_cnt;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_wait_cnt == WC_LAST) begin
                    w_state_nxt = ST_DONE;
                    if (r_owner) begin
                        w_dma_rdy_nxt = 1'b1;
                        if (!r_we_intent) begin
                            w_dma_rdata_nxt = io_bus.mem_rdata;
                        end else begin
                            w_dma_rdata_nxt = r_dma_rdata;
                        end
                    end else begin
                        w_cpu_rdy_nxt = 1'b1;
                        if (!r_we_intent) begin
                            w_cpu_rdata_nxt = io_bus.mem_rdata;
                        end else begin
                            w_cpu_rdata_nxt = r_cpu_rdata;
                        end
                    end
                end else begin
                    w_wait_nxt   = r_wait_cnt + WC_ONE;
                    w_mem_en_nxt = 1'b1;
                    w_mem_we_nxt = r_we_intent && ((r_wait_cnt + WC_ONE) == WC_LAST);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt   <= {WW{1'b0}};
            r_starve_cnt <= {SW{1'b0}};
            r_we_intent  <= 1'b0;
            r_owner      <= 1'b0;
            r_mem_addr   <= {AW{1'b0}};
            r_mem_wdata  <= {DW{1'b0}};
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_rdy    <= 1'b0;
            r_dma_rdy    <= 1'b0;
            r_cpu_rdata  <= {DW{1'b0}};
            r_dma_rdata  <= {DW{1'b0}};
        end else begin
            r_wait_cnt   <= w_wait_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_we_intent  <= w_we_intent_nxt;
            r_owner      <= w_owner_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_cpu_rdy    <= w_cpu_rdy_nxt;
            r_dma_rdy    <= w_dma_rdy_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_dma_rdata  <= w_dma_rdata_nxt;
        end
    end

    assign io_bus.cpu_rdata = r_cpu_rdata;
    assign io_bus.cpu_rdy   = r_cpu_rdy;
    assign io_bus.dma_rdata = r_dma_rdata;
    assign io_bus.dma_rdy   = r_dma_rdy;
    assign io_bus.mem_en    = r_mem_en;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.owner     = r_owner;

endmodule
